// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write ports, optional
// write-to-read bypass and an integrated busy-bit scoreboard.
// Register 0 is hardwired to zero and has no storage.
module regfile_mp_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    localparam logic BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [NREGS-1:0] busy_q;

    // Data array: port 1 wins a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < int'(NREGS); r++) begin
                if (we1 && (waddr1 == AW'(r))) begin
                    regs[r] <= wdata1;
                end else if (we0 && (waddr0 == AW'(r))) begin
                    regs[r] <= wdata0;
                end
            end
        end
    end

    // Scoreboard: flush > issue (newer producer) > writeback clear > hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q[0] <= 1'b0;
            for (int r = 1; r < int'(NREGS); r++) begin
                if (flush) begin
                    busy_q[r] <= 1'b0;
                end else if (issue_valid && (issue_rd == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if ((we0 && (waddr0 == AW'(r))) ||
                             (we1 && (waddr1 == AW'(r)))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy_q;

    // Combinational read ports with optional forwarding of in-flight writes
    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            live;
        logic            hit1;
        logic            hit0;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[k*AW +: AW];
        assign live = rst_n && (addr != '0);
        assign hit1 = BYP_EN && we1 && (waddr1 == addr);
        assign hit0 = BYP_EN && we0 && (waddr0 == addr);

        // Select forwarded or stored data; forwarded data clears busy
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (live) begin
                if (hit1) begin
                    data = wdata1;
                end else if (hit0) begin
                    data = wdata0;
                end else begin
                    data = regs[addr];
                end
                bsy = busy_q[addr] && !(hit1 || hit0);
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = bsy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized bench for regfile_mp_sb: a bypassing and a non-bypassing
// instance share stimulus and are compared to an array-based model.
module tb_regfile_mp_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data_b, rd_data_n;
    logic [NRD-1:0]       rd_busy_b, rd_busy_n;
    logic                 we0, we1;
    logic [AW-1:0]        waddr0, waddr1;
    logic [XLEN-1:0]      wdata0, wdata1;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 flush;
    logic [NREGS-1:0]     busy_vec_b, busy_vec_n;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural values and busy flags
    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] bsy;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < int'(NREGS); r++) mem[r] = '0;
        bsy = '0;
    endfunction

    // Expected read value from the register-file rules
    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp && we1 && waddr1 == a) return wdata1;
        if (byp && we0 && waddr0 == a) return wdata0;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
        return bsy[a];
    endfunction

    // Commit one clock edge to the model: writes in order, then busy rules
    function automatic void model_edge();
        if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
        if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
        if (flush) begin
            bsy = '0;
        end else begin
            if (we0) bsy[waddr0] = 1'b0;
            if (we1) bsy[waddr1] = 1'b0;
            if (issue_valid) bsy[issue_rd] = 1'b1;
        end
        bsy[0] = 1'b0;
    endfunction

    task automatic check_comb();
        for (int k = 0; k < int'(NRD); k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            check($sformatf("rd_data_byp[%0d] a=%0d", k, a), 64'(rd_data_b[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b1)));
            check($sformatf("rd_data_nob[%0d] a=%0d", k, a), 64'(rd_data_n[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b0)));
            check($sformatf("rd_busy_byp[%0d] a=%0d", k, a), 64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b1)));
            check($sformatf("rd_busy_nob[%0d] a=%0d", k, a), 64'(rd_busy_n[k]), 64'(exp_busy(a, 1'b0)));
        end
        check("busy_vec_byp", 64'(busy_vec_b), 64'(bsy));
        check("busy_vec_nob", 64'(busy_vec_n), 64'(bsy));
    endtask

    // Apply inputs away from the edge, then check the combinational view
    task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                         input logic iv, input logic [AW-1:0] ird, input logic fl,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(negedge clk);
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        issue_valid = iv; issue_rd = ird; flush = fl;
        rd_addr = {ra1, ra0};
        #1;
        check_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check("busy_vec_byp_post", 64'(busy_vec_b), 64'(bsy));
        check("busy_vec_nob_post", 64'(busy_vec_n), 64'(bsy));
    endtask

    task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    initial begin
        rst_n = 1'b0;
        we0 = 0; waddr0 = 0; wdata0 = 0; we1 = 0; waddr1 = 0; wdata1 = 0;
        issue_valid = 0; issue_rd = 0; flush = 0; rd_addr = '0;
        model_reset();
        #12;
        check_comb();
        check("reset_rd_data", 64'(rd_data_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write via port 0; write to x0 discarded
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 0); tick();
        idle_read(5, 0);
        check("t1_x5", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 5); tick();
        idle_read(0, 5);
        check("t1_x0", 64'(rd_data_b[31:0]), 64'h0);

        // Same-address collision, port 1 wins
        drive(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 0, 7, 7);
        check("t2_fwd", 64'(rd_data_b[31:0]), 64'h2222);
        tick();
        idle_read(7, 7);
        check("t2_store", 64'(rd_data_n[31:0]), 64'h2222);

        // Non-bypass read shows old value until the edge
        drive(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 3, 3);
        check("t3_old", 64'(rd_data_n[31:0]), 64'h0);
        tick();
        idle_read(3, 3);
        check("t3_new", 64'(rd_data_n[31:0]), 64'hA5A5A5A5);

        // Scoreboard: issue, writeback, issue+writeback together
        drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0); tick();
        check("t4_busy9", 64'(busy_vec_b[9]), 64'd1);
        drive(0, 0, 0, 1, 9, 32'h55, 0, 0, 0, 9, 0);
        check("t4_fwd_busy", 64'(rd_busy_b[0]), 64'd0);
        check("t4_nob_busy", 64'(rd_busy_n[0]), 64'd1);
        tick();
        check("t4_clear9", 64'(busy_vec_b[9]), 64'd0);
        drive(0, 0, 0, 1, 9, 32'h66, 1, 9, 0, 9, 0); tick();
        check("t4_reissue9", 64'(busy_vec_b[9]), 64'd1);

        // Flush beats issue; write in flush cycle commits
        drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 4); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 2, 4); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 31, 0, 31, 4); tick();
        drive(1, 4, 32'h77, 0, 0, 0, 1, 6, 1, 4, 6); tick();
        check("t5_flush", 64'(busy_vec_b), 64'd0);
        idle_read(4, 6);
        check("t5_x4", 64'(rd_data_n[31:0]), 64'h77);

        // Mid-cycle asynchronous reset
        drive(1, 10, 32'hCAFE, 0, 0, 0, 1, 10, 0, 10, 10); tick();
        idle_read(10, 10);
        check("t6_pre", 64'(rd_data_b[31:0]), 64'hCAFE);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_comb();
        check("t6_rd_zero", 64'(rd_data_b), 64'd0);
        check("t6_busy_zero", 64'(busy_vec_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_read(10, 10);
        check("t6_x10", 64'(rd_data_b[31:0]), 64'd0);
        drive(1, 10, 32'hBEEF, 0, 0, 0, 1, 11, 0, 10, 11); tick();
        idle_read(10, 11);
        check("t6_x10_new", 64'(rd_data_n[31:0]), 64'hBEEF);
        check("t6_busy11", 64'(rd_busy_n[1]), 64'd1);

        // Randomized traffic, biased toward low addresses for collisions
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a0, a1, ir, r0, r1;
            a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ir = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom);
            drive(1'($urandom_range(0, 1)), a0, $urandom,
                  1'($urandom_range(0, 1)), a1, $urandom,
                  1'($urandom_range(0, 1)), ir, 1'($urandom_range(0, 15) == 0),
                  r0, r1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core.
- NRD combinational read ports and two write ports (ALU/EX and LSU/WB writeback), with an optional write-to-read bypass.
- Integrated busy-bit scoreboard. Issue marks a destination busy; writeback clears it; a pipeline flush clears all bits. Decode uses the busy outputs to stall.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding; 0 means reads return the pre-edge value.
- AW, $clog2(NREGS), localparam address width; not overridable.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  scoreboard status of the register addressed on each read port.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1; has priority over port 0.
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- issue_valid  in  1  instruction issued with a destination register.
- issue_rd  in  AW  destination register to mark busy.
- flush  in  1  clear all busy bits.
- busy_vec  out  NREGS  current busy bits; bit 0 is always 0.

Behaviour:
Clock and reset
- Single clock clk; reset rst_n is asynchronous, active-low.
- While rst_n=0: all registers = 0, all busy bits = 0. rd_data = 0 on every port, rd_busy = 0, busy_vec = 0.
- Writes, issue and flush are ignored during reset.
- Reset asserted mid-operation discards all state immediately, without waiting for a clock edge.

Writes
- A write takes effect at the rising edge when weN=1 and waddrN!=0.
- Writes with address 0 are discarded.
- If both ports write the same address in one cycle, port 1's data is stored and port 0's write is dropped.
- Different addresses on the two ports both commit in the same cycle.

Reads (combinational, zero latency)
- Address 0 always returns 0.
- BYPASS=1: if we1 && waddr1==rd_addr[k] && addr!=0, the port returns wdata1. Otherwise, if we0 && waddr0==rd_addr[k] && addr!=0, it returns wdata0. Otherwise it returns the stored value.
- BYPASS=0: reads return the stored value only; new data becomes visible the cycle after the write edge.

Scoreboard (per register r != 0, updated at the rising edge, priority high to low)
1. flush=1: busy[r] <= 0 for all r; issue_valid that cycle is ignored. Writes in the same cycle still commit to the data array.
2. issue_valid && issue_rd==r && r!=0: busy[r] <= 1. This wins over a same-cycle writeback to r, because the writeback belongs to the older producer.
3. (we0 && waddr0==r) || (we1 && waddr1==r): busy[r] <= 0.
4. Otherwise busy[r] holds.
- Issue to r0 has no effect.
- Writeback to a register that is not busy is legal and leaves busy = 0.

Read-port busy status
- rd_busy[k] = busy[rd_addr[k]].
- When BYPASS=1 and a write to that address is present in the same cycle, rd_busy[k] is forced to 0, because the data is forwarded.
- rd_busy[k] is 0 for address 0.

Other rules
- No internal pipelining; the only sequential state is the data array and the busy vector.
- The data array is NREGS-1 flops of XLEN bits; r0 is not stored.

Test Plan:
1. Reset, then write 0xDEADBEEF to x5 via port 0. The next cycle, rd_addr[0]=5 returns 0xDEADBEEF. A write of 0x1234 to x0 leaves x0 reading 0.
2. Same-cycle collision: we0 writes 0x1111 to x7 and we1 writes 0x2222 to x7. With BYPASS=1, rd_addr=7 reads 0x2222 in that cycle, and it still reads 0x2222 after the edge.
3. BYPASS=0: write 0xA5A5A5A5 to x3 while reading x3. The read shows the old value 0 in that cycle and 0xA5A5A5A5 the next cycle.
4. Scoreboard sequence:
   - Issue x9: busy_vec[9]=1 after the edge and rd_busy=1 on a port reading x9.
   - Writeback via port 1 to x9 with data 0x55: rd_busy=0 in the same cycle (BYPASS=1), and busy_vec[9]=0 after the edge.
   - Issue x9 and writeback x9 in the same cycle: busy_vec[9]=1 after the edge.
5. Flush:
   - Set x2, x4 and x31 busy, then assert flush together with issue_valid, issue_rd=6. After the edge busy_vec=0, so x6 is not busy either.
   - A write to x4 with data 0x77 in the flush cycle commits.
6. Asynchronous reset: assert rst_n=0 mid-cycle after x10=0xCAFE and x10 busy. rd_data and busy_vec go to 0 immediately. After release, x10 reads 0 and issue/write operate normally.
